// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI byte link.
package spi_pkg;

  localparam int unsigned SPI_DATA_W = 8;

  // Mode 0: SCK idles low, data captured on the leading (rising) edge.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETUP     = 3'd1,
    ST_SHIFT     = 3'd2,
    ST_WAIT_NEXT = 3'd3,
    ST_HOLD      = 3'd4,
    ST_GAP       = 3'd5
  } spi_state_e;

  // The half-period divider is held cleared while the master is waiting for a request.
  function automatic logic div_clear(input spi_state_e st);
    return (st == ST_IDLE) || (st == ST_WAIT_NEXT);
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: one-cycle registered pulse every DIV sys_clk cycles.
module spi_clk_div #(
  parameter int unsigned DIV = 4
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Count 0..DIV-1 and flag the wrap; clr restarts the phase from zero.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || clr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == CNT_MAX);
      cnt  <= (cnt == CNT_MAX) ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_master_xfer.sv
// SPI mode-0 master: one byte per request, CS held low across bytes of a frame.
module spi_master_xfer
  import spi_pkg::*;
#(
  parameter int unsigned DIV    = 4,
  parameter int unsigned DATA_W = SPI_DATA_W
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              last_i,
  output logic              ready_o,
  output logic              busy_o,
  output logic              rx_valid_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              sck_o,
  output logic              sdo_o,
  input  logic              sdi_i,
  output logic              csn_o
);

  localparam int unsigned BIT_W = 3;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  spi_state_e        state;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic              last_q;
  logic [BIT_W-1:0]  bit_cnt;
  logic              tick;
  logic              div_clr_c;
  logic              accept_c;
  logic              lead_c;

  assign div_clr_c = div_clear(state);
  assign accept_c  = start_i & ready_o;
  assign lead_c    = (sck_o == SPI_CPOL);

  spi_clk_div #(
    .DIV (DIV)
  ) u_div (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .clr     (div_clr_c),
    .tick    (tick)
  );

  // Frame sequencer, shift registers and all registered SPI/handshake outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= ST_IDLE;
      sck_o      <= SPI_CPOL;
      csn_o      <= 1'b1;
      sdo_o      <= 1'b0;
      ready_o    <= 1'b1;
      busy_o     <= 1'b0;
      rx_valid_o <= 1'b0;
      rx_data_o  <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      last_q     <= 1'b0;
      bit_cnt    <= '0;
    end else begin
      rx_valid_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          csn_o <= 1'b1;
          sck_o <= SPI_CPOL;
          if (accept_c) begin
            tx_sr   <= tx_data_i;
            last_q  <= last_i;
            sdo_o   <= tx_data_i[DATA_W-1];
            csn_o   <= 1'b0;
            busy_o  <= 1'b1;
            ready_o <= 1'b0;
            state   <= ST_SETUP;
          end else begin
            busy_o  <= 1'b0;
            ready_o <= 1'b1;
          end
        end

        ST_SETUP: begin
          if (tick) begin
            bit_cnt <= '0;
            state   <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (tick) begin
            sck_o <= ~sck_o;
            if (lead_c ^ SPI_CPHA) begin
              rx_sr <= {rx_sr[DATA_W-2:0], sdi_i};
            end
            if (!lead_c) begin
              // Trailing edge closes a bit: either advance or finish the byte.
              if (bit_cnt == LAST_BIT) begin
                bit_cnt    <= '0;
                rx_data_o  <= rx_sr;
                rx_valid_o <= 1'b1;
                state      <= last_q ? ST_HOLD : ST_WAIT_NEXT;
              end else begin
                bit_cnt <= bit_cnt + BIT_W'(1);
                tx_sr   <= tx_sr << 1;
                sdo_o   <= tx_sr[DATA_W-2];
              end
            end
          end
        end

        ST_WAIT_NEXT: begin
          csn_o <= 1'b0;
          sck_o <= SPI_CPOL;
          if (accept_c) begin
            tx_sr   <= tx_data_i;
            last_q  <= last_i;
            sdo_o   <= tx_data_i[DATA_W-1];
            ready_o <= 1'b0;
            state   <= ST_SHIFT;
          end else begin
            ready_o <= 1'b1;
          end
        end

        ST_HOLD: begin
          if (tick) begin
            csn_o <= 1'b1;
            state <= ST_GAP;
          end
        end

        ST_GAP: begin
          if (tick) begin
            busy_o <= 1'b0;
            state  <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_xfer.sv
// Bench for spi_master_xfer: mode-0 slave model, timing/data scoreboard, DIV=4 and DIV=2 instances.
module tb_spi_master_xfer;

  localparam int TMO = 4000;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       start_i = 1'b0;
  logic       last_i  = 1'b0;
  logic [7:0] tx_data_i = 8'h00;
  logic       sdi_i = 1'b0;
  logic       sel = 1'b0;

  always #5 sys_clk = ~sys_clk;

  logic       ready4, busy4, rxv4, sck4, sdo4, csn4;
  logic [7:0] rxd4;
  logic       ready2, busy2, rxv2, sck2, sdo2, csn2;
  logic [7:0] rxd2;
  logic       start4, start2;

  assign start4 = start_i & ~sel;
  assign start2 = start_i & sel;

  logic       ready_o, busy_o, rx_valid_o, sck_o, sdo_o, csn_o;
  logic [7:0] rx_data_o;
  assign ready_o    = sel ? ready2 : ready4;
  assign busy_o     = sel ? busy2  : busy4;
  assign rx_valid_o = sel ? rxv2   : rxv4;
  assign rx_data_o  = sel ? rxd2   : rxd4;
  assign sck_o      = sel ? sck2   : sck4;
  assign sdo_o      = sel ? sdo2   : sdo4;
  assign csn_o      = sel ? csn2   : csn4;

  spi_master_xfer #(.DIV(4)) u_dut4 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start_i(start4), .tx_data_i(tx_data_i),
    .last_i(last_i), .ready_o(ready4), .busy_o(busy4), .rx_valid_o(rxv4),
    .rx_data_o(rxd4), .sck_o(sck4), .sdo_o(sdo4), .sdi_i(sdi_i), .csn_o(csn4)
  );

  spi_master_xfer #(.DIV(2)) u_dut2 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start_i(start2), .tx_data_i(tx_data_i),
    .last_i(last_i), .ready_o(ready2), .busy_o(busy2), .rx_valid_o(rxv2),
    .rx_data_o(rxd2), .sck_o(sck2), .sdo_o(sdo2), .sdi_i(sdi_i), .csn_o(csn2)
  );

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  logic rst_q = 1'b1;

  always @(posedge sys_clk) cyc <= cyc + 1;
  always @(posedge sys_clk) rst_q <= sys_rst;

  // Scoreboard queues: bytes the slave returns, and what the master/slave must observe.
  logic [7:0] slave_tx_q[$];
  logic [7:0] slave_got_q[$];
  logic [7:0] exp_rx_q[$];
  logic [7:0] exp_mosi_q[$];
  int         exp_cyc_q[$];

  int sck_rises = 0;
  int s_bytes = 0;
  int pulses = 0;
  int csn_rises = 0;
  int sdo_low = 0;
  int last_pulse_cyc = 0;
  int last_csn_rise_cyc = 0;
  int acc_cyc = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Behavioural mode-0 slave: samples MOSI on SCK rise, shifts MISO on SCK fall.
  logic [7:0] s_sr = 8'h00;
  logic [7:0] s_cap = 8'h00;
  int         s_bits = 0;
  int         s_idx = 0;
  logic       s_csn_p = 1'b1;
  logic       s_sck_p = 1'b0;

  always @(csn_o, sck_o) begin
    if (csn_o !== s_csn_p) begin
      s_bits = 0;
      if (csn_o === 1'b0) begin
        s_sr = (s_idx < slave_tx_q.size()) ? slave_tx_q[s_idx] : 8'h00;
        if (s_idx < slave_tx_q.size()) s_idx++;
        sdi_i = s_sr[7];
      end
    end
    if (sck_o !== s_sck_p && csn_o === 1'b0) begin
      if (sck_o === 1'b1) begin
        s_cap = {s_cap[6:0], sdo_o};
        sck_rises++;
      end else if (sck_o === 1'b0) begin
        s_bits++;
        if (s_bits == 8) begin
          slave_got_q.push_back(s_cap);
          s_bytes++;
          s_bits = 0;
          s_sr = (s_idx < slave_tx_q.size()) ? slave_tx_q[s_idx] : 8'h00;
          if (s_idx < slave_tx_q.size()) s_idx++;
        end else begin
          s_sr = s_sr << 1;
        end
        sdi_i = s_sr[7];
      end
    end
    s_csn_p = csn_o;
    s_sck_p = sck_o;
  end

  // Per-cycle compare against the scoreboard and the frame-level protocol rules.
  logic prev_csn = 1'b1;
  logic prev_sck = 1'b0;
  int   phase_len = 0;
  int   rise_idx = 0;
  int   got_idx = 0;

  task automatic monitor_loop();
    int div;
    forever begin
      @(negedge sys_clk);
      div = sel ? 2 : 4;
      if (rx_valid_o) begin
        pulses++;
        last_pulse_cyc = cyc;
        if (exp_rx_q.size() == 0) check("unexpected_rx_valid", 1, 0);
        else begin
          check("rx_data", rx_data_o, exp_rx_q.pop_front());
          check("rx_latency", cyc, exp_cyc_q.pop_front());
        end
      end
      while (got_idx < slave_got_q.size()) begin
        if (exp_mosi_q.size() == 0) check("unexpected_slave_byte", 1, 0);
        else check("slave_saw", slave_got_q[got_idx], exp_mosi_q.pop_front());
        got_idx++;
      end
      if (csn_o) check("sck_idle_when_deselected", sck_o, 0);
      if (ready_o) check("no_pulse_while_ready", rx_valid_o, 0);
      if (csn_o != prev_csn) begin
        if (!rst_q) check("sck_low_at_cs_edge", {prev_sck, sck_o}, 0);
        if (csn_o) begin
          csn_rises++;
          last_csn_rise_cyc = cyc;
        end
      end
      if (!csn_o && !rst_q) begin
        if (sck_o != prev_sck) begin
          if (sck_o) begin
            if (rise_idx % 8 != 0) check("sck_low_phase", phase_len, div);
            rise_idx++;
          end else begin
            check("sck_high_phase", phase_len, div);
          end
          phase_len = 1;
        end else begin
          phase_len++;
        end
        if (!sdo_o) sdo_low++;
      end else begin
        rise_idx = 0;
        phase_len = 0;
      end
      prev_csn = csn_o;
      prev_sck = sck_o;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge sys_clk);
      if (ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("ready_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge sys_clk);
      if (!busy_o && ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("idle_timeout", 0, 1);
  endtask

  task automatic expect_byte(input logic [7:0] t, input logic [7:0] r);
    slave_tx_q.push_back(r);
    exp_rx_q.push_back(r);
    exp_mosi_q.push_back(t);
  endtask

  // One request; pulse lands 17 half-periods (+1) after an IDLE accept, 16 after WAIT_NEXT.
  task automatic send_byte(input logic [7:0] b, input logic l);
    bit ok;
    int n;
    wait_ready(ok);
    if (ok) begin
      n = busy_o ? 16 : 17;
      start_i   = 1'b1;
      tx_data_i = b;
      last_i    = l;
      acc_cyc   = cyc + 1;
      exp_cyc_q.push_back(cyc + 2 + n * (sel ? 2 : 4));
      @(negedge sys_clk);
      start_i = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int p0, r0, c0, b0, d0;
    bit ok;
    logic [7:0] tb[3];
    logic [7:0] rb[3];
    int n;

    idle(3);
    check("rst_ready", ready_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_rx_valid", rx_valid_o, 0);
    check("rst_rx_data", rx_data_o, 8'h00);
    check("rst_sck", sck_o, 0);
    check("rst_sdo", sdo_o, 0);
    check("rst_csn", csn_o, 1);
    check("rst_csn_div2", csn2, 1);
    sys_rst = 1'b0;
    prev_csn = csn_o;
    prev_sck = sck_o;
    fork
      monitor_loop();
    join_none
    idle(2);

    // 1: single byte, last=1
    p0 = pulses; r0 = sck_rises; b0 = s_bytes;
    expect_byte(8'hA5, 8'h3C);
    send_byte(8'hA5, 1'b1);
    wait_idle();
    check("t1_latency", last_pulse_cyc - acc_cyc, 69);
    check("t1_rx_data", rx_data_o, 8'h3C);
    check("t1_pulses", pulses - p0, 1);
    check("t1_sck_rises", sck_rises - r0, 8);
    check("t1_slave_bytes", s_bytes - b0, 1);
    check("t1_csn_high", csn_o, 1);
    check("t1_hold_ticks", last_csn_rise_cyc - last_pulse_cyc, 4);

    // 2: two-byte frame, CS held low between bytes
    p0 = pulses; r0 = sck_rises; c0 = csn_rises;
    expect_byte(8'h0F, 8'h5A);
    expect_byte(8'hF0, 8'hC3);
    send_byte(8'h0F, 1'b0);
    idle(3);
    send_byte(8'hF0, 1'b1);
    wait_idle();
    check("t2_pulses", pulses - p0, 2);
    check("t2_sck_rises", sck_rises - r0, 16);
    check("t2_csn_rises", csn_rises - c0, 1);
    check("t2_rx_data", rx_data_o, 8'hC3);

    // 3: start while shifting is ignored
    p0 = pulses; r0 = sck_rises; b0 = s_bytes;
    expect_byte(8'hC6, 8'h19);
    send_byte(8'hC6, 1'b1);
    idle(24);
    start_i = 1'b1; tx_data_i = 8'h5A; last_i = 1'b0;
    idle(12);
    start_i = 1'b0;
    wait_idle();
    idle(10);
    check("t3_pulses", pulses - p0, 1);
    check("t3_sck_rises", sck_rises - r0, 8);
    check("t3_slave_bytes", s_bytes - b0, 1);

    // 4: reset after the 4th SCK rise aborts the frame
    p0 = pulses; r0 = sck_rises;
    expect_byte(8'h55, 8'h99);
    send_byte(8'h55, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      if (sck_rises - r0 >= 4) begin
        ok = 1'b1;
        break;
      end
      @(negedge sys_clk);
    end
    check("t4_reach_4th_rise", ok, 1);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check("t4_csn", csn_o, 1);
    check("t4_sck", sck_o, 0);
    check("t4_busy", busy_o, 0);
    check("t4_rx_valid", rx_valid_o, 0);
    check("t4_rx_data", rx_data_o, 8'h00);
    sys_rst = 1'b0;
    exp_rx_q.delete();
    exp_mosi_q.delete();
    exp_cyc_q.delete();
    idle(3);
    expect_byte(8'h81, 8'h7E);
    send_byte(8'h81, 1'b1);
    wait_idle();
    check("t4_pulses", pulses - p0, 1);
    check("t4_rx_data_after", rx_data_o, 8'h7E);

    // 5: DIV=2, all-ones out, all-zeros back
    sel = 1'b1;
    idle(2);
    p0 = pulses; r0 = sck_rises; d0 = sdo_low;
    expect_byte(8'hFF, 8'h00);
    send_byte(8'hFF, 1'b1);
    wait_idle();
    check("t5_sdo_low_cycles", sdo_low - d0, 0);
    check("t5_rx_data", rx_data_o, 8'h00);
    check("t5_sck_rises", sck_rises - r0, 8);
    check("t5_pulses", pulses - p0, 1);

    // Randomized frames on both divider settings
    for (int f = 0; f < 24; f++) begin
      sel = 1'($urandom_range(0, 1));
      n = int'($urandom_range(1, 3));
      p0 = pulses;
      for (int i = 0; i < n; i++) begin
        tb[i] = 8'($urandom);
        rb[i] = 8'($urandom);
        expect_byte(tb[i], rb[i]);
      end
      for (int i = 0; i < n; i++) begin
        idle(int'($urandom_range(0, 3)));
        send_byte(tb[i], (i == n - 1));
      end
      wait_idle();
      check("rand_pulses", pulses - p0, n);
    end

    idle(5);
    check("queues_drained", exp_rx_q.size() + exp_mosi_q.size() + exp_cyc_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
